// File: rtl/score_digit_converter_if.sv
`default_nettype none
// ============================================================================
// Module      : score_digit_converter_if
// Description : Bundle of frame trigger, binary scores and BCD/blank results
//               exchanged between the game core and the score digit converter.
//   master : drives frame_start, score, high_score; observes the results
//   slave  : the converter; consumes the inputs and drives score_digits,
//            high_digits, score_blank, high_blank, score_sat, busy, done
// Revision    : 1.0 - initial release
// ============================================================================
interface score_digit_converter_if #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 3
);
  logic                  frame_start;
  logic [IN_WIDTH-1:0]   score;
  logic [IN_WIDTH-1:0]   high_score;
  logic [4*DIGITS-1:0]   score_digits;
  logic [4*DIGITS-1:0]   high_digits;
  logic [DIGITS-1:0]     score_blank;
  logic [DIGITS-1:0]     high_blank;
  logic                  score_sat;
  logic                  busy;
  logic                  done;

  modport master (
    output frame_start, score, high_score,
    input  score_digits, high_digits, score_blank, high_blank,
           score_sat, busy, done
  );

  modport slave (
    input  frame_start, score, high_score,
    output score_digits, high_digits, score_blank, high_blank,
           score_sat, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/score_digit_converter.sv
`default_nettype none
// ============================================================================
// Module      : score_digit_converter
// Description : Once per frame, clamps score and high_score to MAX_VALUE and
//               converts both to BCD with leading-zero blank masks using one
//               shared iterative double-dabble engine. Results are held
//               between conversions.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : slave side of score_digit_converter_if (frame_start, score,
//            high_score in; digits, blank masks, score_sat, busy, done out)
// Revision    : 1.0 - initial release
// ============================================================================
module score_digit_converter #(
  parameter int IN_WIDTH   = 32,
  parameter int DIGITS     = 3,
  parameter int MAX_VALUE  = 10**DIGITS - 1,
  parameter int SHIFT_BITS = $clog2(MAX_VALUE + 1)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  score_digit_converter_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(SHIFT_BITS + 1);

  localparam logic [IN_WIDTH-1:0]   C_MAX_IN   = IN_WIDTH'(MAX_VALUE);
  localparam logic [SHIFT_BITS-1:0] C_MAX_BIN  = SHIFT_BITS'(MAX_VALUE);
  localparam logic [CNT_W-1:0]      C_LAST_CNT = CNT_W'(SHIFT_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT_S = 3'd2,
    ST_STORE_S = 3'd3,
    ST_LOAD_H  = 3'd4,
    ST_SHIFT_H = 3'd5,
    ST_STORE_H = 3'd6
  } state_t;

  state_t                  state_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [SHIFT_BITS-1:0]   bin_q;
  logic [SHIFT_BITS-1:0]   shadow_q;
  logic                    sat_pend_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BCD_W-1:0]        score_digits_q;
  logic [BCD_W-1:0]        high_digits_q;
  logic [DIGITS-1:0]       score_blank_q;
  logic [DIGITS-1:0]       high_blank_q;
  logic                    score_sat_q;
  logic                    busy_q;
  logic                    done_q;

  // Clamped snapshots of both inputs
  logic                    score_over_d;
  logic                    high_over_d;
  logic [SHIFT_BITS-1:0]   score_clamp_d;
  logic [SHIFT_BITS-1:0]   high_clamp_d;

  assign score_over_d  = (bus.score > C_MAX_IN);
  assign high_over_d   = (bus.high_score > C_MAX_IN);
  assign score_clamp_d = score_over_d ? C_MAX_BIN : bus.score[SHIFT_BITS-1:0];
  assign high_clamp_d  = high_over_d  ? C_MAX_BIN : bus.high_score[SHIFT_BITS-1:0];

  // Double-dabble step: add-3 correction on every nibble >= 5, then shift
  // {bcd, bin} left as one vector. The top bit shifted out is always zero
  // because the clamped value fits in DIGITS decimal digits.
  logic [BCD_W-1:0]             bcd_adj;
  logic [BCD_W+SHIFT_BITS-1:0]  shift_d;
  logic [BCD_W-1:0]             bcd_d;
  logic [SHIFT_BITS-1:0]        bin_d;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                          : bcd_q[4*i +: 4];
  end

  assign shift_d = {bcd_adj, bin_q} << 1;
  assign bcd_d   = shift_d[BCD_W+SHIFT_BITS-1 : SHIFT_BITS];
  assign bin_d   = shift_d[SHIFT_BITS-1:0];

  // Leading-zero mask of the finished accumulator: digit i is blank when it
  // and every digit above it are zero. The ones digit is never blanked.
  logic [DIGITS:1]   zero_from;
  logic [DIGITS-1:0] blank_d;

  assign zero_from[DIGITS] = 1'b1;
  assign blank_d[0]        = 1'b0;

  for (genvar i = 1; i < DIGITS; i++) begin : g_blank
    assign zero_from[i] = zero_from[i+1] && (bcd_q[4*i +: 4] == 4'd0);
    assign blank_d[i]   = zero_from[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      bcd_q          <= '0;
      bin_q          <= '0;
      shadow_q       <= '0;
      sat_pend_q     <= 1'b0;
      cnt_q          <= '0;
      score_digits_q <= '0;
      high_digits_q  <= '0;
      score_blank_q  <= '0;
      high_blank_q   <= '0;
      score_sat_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.frame_start) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Both inputs captured on the same edge so the pair is coherent
          bin_q      <= score_clamp_d;
          shadow_q   <= high_clamp_d;
          sat_pend_q <= score_over_d;
          bcd_q      <= '0;
          cnt_q      <= '0;
          busy_q     <= 1'b1;
          state_q    <= ST_SHIFT_S;
        end
        ST_SHIFT_S: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_CNT) begin
            state_q <= ST_STORE_S;
          end
        end
        ST_STORE_S: begin
          score_digits_q <= bcd_q;
          score_blank_q  <= blank_d;
          score_sat_q    <= sat_pend_q;
          state_q        <= ST_LOAD_H;
        end
        ST_LOAD_H: begin
          bin_q   <= shadow_q;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_SHIFT_H;
        end
        ST_SHIFT_H: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_CNT) begin
            state_q <= ST_STORE_H;
          end
        end
        ST_STORE_H: begin
          high_digits_q <= bcd_q;
          high_blank_q  <= blank_d;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.score_digits = score_digits_q;
  assign bus.high_digits  = high_digits_q;
  assign bus.score_blank  = score_blank_q;
  assign bus.high_blank   = high_blank_q;
  assign bus.score_sat    = score_sat_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_score_digit_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_digit_converter
// Description : Self-checking bench for score_digit_converter. A timeline
//               model computes the expected digits, blank masks, sat, busy
//               and done from plain decimal arithmetic; a compare process
//               checks every cycle; directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_digit_converter;

  localparam int IN_W = 32;
  localparam int DIG  = 3;
  localparam int MAXV = 999;
  localparam int SB   = 10;

  logic clk;
  logic reset;

  score_digit_converter_if #(.IN_WIDTH(IN_W), .DIGITS(DIG)) bus ();

  score_digit_converter #(.IN_WIDTH(IN_W), .DIGITS(DIG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of min(x, MAXV), ones digit in the low nibble
  function automatic logic [11:0] to_bcd(input logic [31:0] x);
    longint     v;
    logic [11:0] r;
    v = (x > 32'(MAXV)) ? longint'(MAXV) : longint'(x);
    r = '0;
    for (int i = 0; i < DIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] to_blank(input logic [11:0] d);
    logic [2:0] b;
    bit         z;
    b = '0;
    z = 1'b1;
    for (int i = DIG - 1; i >= 1; i--) begin
      z    = z && (d[4*i +: 4] == 4'd0);
      b[i] = z;
    end
    return b;
  endfunction

  // Timeline model: 'age' counts edges since frame_start was accepted
  int          age;
  logic [31:0] snap_s, snap_h;
  logic [11:0] exp_sd, exp_hd;
  logic [2:0]  exp_sb, exp_hb;
  logic        exp_sat, exp_busy, exp_done;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      age = 0; snap_s = '0; snap_h = '0;
      exp_sd = '0; exp_hd = '0; exp_sb = '0; exp_hb = '0;
      exp_sat = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (age == 0) begin
        if (bus.frame_start) age = 1;
      end else begin
        if (age == 1) begin
          snap_s   = bus.score;
          snap_h   = bus.high_score;
          exp_busy = 1'b1;
        end
        if (age == SB + 2) begin
          exp_sd  = to_bcd(snap_s);
          exp_sb  = to_blank(exp_sd);
          exp_sat = (snap_s > 32'(MAXV));
        end
        if (age == 2*SB + 4) begin
          exp_hd   = to_bcd(snap_h);
          exp_hb   = to_blank(exp_hd);
          exp_done = 1'b1;
          exp_busy = 1'b0;
          age      = 0;
        end else begin
          age++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("score_digits", 32'(bus.score_digits), 32'(exp_sd));
    check("high_digits",  32'(bus.high_digits),  32'(exp_hd));
    check("score_blank",  32'(bus.score_blank),  32'(exp_sb));
    check("high_blank",   32'(bus.high_blank),   32'(exp_hb));
    check("score_sat",    32'(bus.score_sat),    32'(exp_sat));
    check("busy",         32'(bus.busy),         32'(exp_busy));
    check("done",         32'(bus.done),         32'(exp_done));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      lat++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    int lat;
    int nd;
    reset           = 1'b0;
    bus.frame_start = 1'b0;
    bus.score       = '0;
    bus.high_score  = '0;

    // Idle after reset: nothing happens without frame_start
    tick(); tick(); tick();
    reset = 1'b1;
    count_done(100, nd);
    check("idle_done_count", 32'(nd), 32'd0);
    check("idle_digits", 32'(bus.score_digits), 32'h0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Basic conversion and latency
    bus.score = 32'd42; bus.high_score = 32'd7;
    pulse();
    wait_done(40, lat);
    check("latency", 32'(lat), 32'd24);
    check("t2_sd", 32'(bus.score_digits), 32'h042);
    check("t2_sb", 32'(bus.score_blank), 32'b100);
    check("t2_hd", 32'(bus.high_digits), 32'h007);
    check("t2_hb", 32'(bus.high_blank), 32'b110);
    tick(); tick();

    // Saturation
    bus.score = 32'd1000; bus.high_score = 32'hFFFF_FFFF;
    pulse();
    wait_done(40, lat);
    check("t3_sd", 32'(bus.score_digits), 32'h999);
    check("t3_sat", 32'(bus.score_sat), 32'd1);
    check("t3_hd", 32'(bus.high_digits), 32'h999);
    tick(); tick();
    bus.score = 32'd999; bus.high_score = 32'd999;
    pulse();
    wait_done(40, lat);
    check("t3b_sd", 32'(bus.score_digits), 32'h999);
    check("t3b_sat", 32'(bus.score_sat), 32'd0);
    tick(); tick();

    // Retrigger while busy and input change after snapshot
    bus.score = 32'd123; bus.high_score = 32'd5;
    pulse();
    tick();
    bus.score = 32'd456;
    tick();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    count_done(40, nd);
    check("t4_done_count", 32'(nd), 32'd1);
    check("t4_sd", 32'(bus.score_digits), 32'h123);

    // Reset mid-conversion
    bus.score = 32'd321; bus.high_score = 32'd654;
    pulse();
    for (int i = 0; i < 10; i++) tick();
    #1 reset = 1'b0;
    #1;
    check("t5_sd", 32'(bus.score_digits), 32'h0);
    check("t5_hd", 32'(bus.high_digits), 32'h0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_done", 32'(bus.done), 32'd0);
    tick();
    reset = 1'b1;
    count_done(30, nd);
    check("t5_no_done", 32'(nd), 32'd0);
    pulse();
    wait_done(40, lat);
    check("t5_sd_after", 32'(bus.score_digits), 32'h321);
    check("t5_hd_after", 32'(bus.high_digits), 32'h654);
    tick(); tick();

    // Zero and exact hundred
    bus.score = 32'd0; bus.high_score = 32'd100;
    pulse();
    wait_done(40, lat);
    check("t6_sd", 32'(bus.score_digits), 32'h000);
    check("t6_sb", 32'(bus.score_blank), 32'b110);
    check("t6_hd", 32'(bus.high_digits), 32'h100);
    check("t6_hb", 32'(bus.high_blank), 32'b000);
    tick(); tick();

    // Randomized frames with retriggers and inputs changing mid-flight
    for (int f = 0; f < 60; f++) begin
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0: begin if (k == 0) bus.score = $urandom_range(0, 999); else bus.high_score = $urandom_range(0, 999); end
          1: begin if (k == 0) bus.score = $urandom_range(995, 1005); else bus.high_score = $urandom_range(995, 1005); end
          2: begin if (k == 0) bus.score = $urandom; else bus.high_score = $urandom; end
          default: begin if (k == 0) bus.score = $urandom_range(0, 20); else bus.high_score = $urandom_range(0, 20); end
        endcase
      end
      pulse();
      for (int c = 0; c < 26; c++) begin
        bus.frame_start = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) bus.score = $urandom;
        if ($urandom_range(0, 2) == 0) bus.high_score = $urandom_range(0, 1200);
        tick();
      end
      bus.frame_start = 1'b0;
      for (int c = 0; c < 27; c++) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
